// File: rtl/hv_seq_pkg.sv
// hv_seq_pkg: shared state encoding and widths for the hypervector phase sequencer.
package hv_seq_pkg;
  localparam int ITEM_W = 16;
  localparam int ADDR_W = 20;
  localparam int CYC_W  = 32;
  typedef enum logic [2:0] {IDLE, GEN, SETTLE, RUN, DONE} seq_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else q <= clr ? '0 : (en && !(&q)) ? q + 1'b1 : q;
endmodule

// File: rtl/hv_sequencer.sv
// hv_sequencer: drives gen -> settle -> run -> done for the hypervector datapath,
// with item-memory addressing, latched bounds, cycle count and a stall watchdog.
module hv_sequencer
  import hv_seq_pkg::*;
#(
  parameter int unsigned      SETTLE_CYCLES = 2,
  parameter logic [CYC_W-1:0] TIMEOUT       = 32'h00FF_FFFF
) (
  input  logic              AXIS_ACLK,
  input  logic              AXIS_ARESETN,
  input  logic              start,
  input  logic              abort,
  input  logic              done_clr,
  input  logic [ITEM_W-1:0] cfg_item_num,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic [ADDR_W-1:0] cfg_addr_j,
  input  logic              m_valid,
  input  logic              m_ready,
  input  logic              m_last,
  output logic              gen,
  output logic [ITEM_W-1:0] item_a,
  output logic              run,
  output logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_j,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CYC_W-1:0]  cycles
);
  seq_state_t state, nxt;
  logic [ITEM_W-1:0] item_num;
  logic [31:0]       settle_cnt;
  logic [CYC_W-1:0]  wd;
  logic beat, last_beat, tmo, go, first_kind;
  assign beat       = m_valid & m_ready;
  assign last_beat  = beat & m_last;
  assign tmo        = (state == RUN) & ~beat & (wd == TIMEOUT - 32'd1);
  assign go         = start & ~abort & ((state == IDLE) | (state == DONE));
  assign first_kind = cfg_item_num != '0;
  always_comb begin
    nxt = state;
    if (abort && state inside {GEN, SETTLE, RUN}) nxt = IDLE;
    else
      case (state)
        IDLE:    nxt = go ? (first_kind ? GEN : SETTLE) : IDLE;
        GEN:     nxt = (item_a == item_num - 1'b1) ? SETTLE : GEN;
        SETTLE:  nxt = (settle_cnt == 32'd0) ? RUN : SETTLE;
        RUN:     nxt = (last_beat || tmo) ? DONE : RUN;
        DONE:    nxt = go ? (first_kind ? GEN : SETTLE) : done_clr ? IDLE : DONE;
        default: nxt = IDLE;
      endcase
  end
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN)
    if (!AXIS_ARESETN) begin
      state      <= IDLE;
      gen        <= 1'b0;
      run        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      item_a     <= '0;
      item_num   <= '0;
      addr_i     <= '0;
      addr_j     <= '0;
      settle_cnt <= '0;
    end else begin
      state <= nxt;
      gen   <= nxt == GEN;
      run   <= nxt == RUN;
      busy  <= nxt inside {GEN, SETTLE, RUN};
      if (go) begin
        item_num <= cfg_item_num;
        addr_i   <= cfg_addr_i;
        addr_j   <= cfg_addr_j;
      end
      item_a     <= go ? '0 : (state == GEN && nxt == GEN) ? item_a + 1'b1 : item_a;
      settle_cnt <= (nxt == SETTLE && state != SETTLE) ? SETTLE_CYCLES :
                    (state == SETTLE) ? settle_cnt - 32'd1 : settle_cnt;
      done       <= (go || done_clr) ? 1'b0 : (state == RUN && nxt == DONE) ? 1'b1 : done;
      err        <= (go || done_clr) ? 1'b0 : (tmo && nxt == DONE) ? 1'b1 : err;
    end
  // busy is the registered view of the state, so it counts exactly the cycles it is seen high
  sat_counter #(.W(CYC_W)) u_cycles (
    .clk(AXIS_ACLK), .rst_n(AXIS_ARESETN), .clr(go), .en(busy), .q(cycles)
  );
  sat_counter #(.W(CYC_W)) u_watchdog (
    .clk(AXIS_ACLK), .rst_n(AXIS_ARESETN), .clr((state != RUN) | beat), .en(1'b1), .q(wd)
  );
  a_gen_run_excl: assert property (@(posedge AXIS_ACLK) disable iff (!AXIS_ARESETN) !(gen && run));
endmodule

// File: tb/tb_hv_sequencer.sv
// tb_hv_sequencer: scoreboard bench for hv_sequencer phases, timing, abort, timeout and reset.
module tb_hv_sequencer;
  logic AXIS_ACLK = 1'b0, AXIS_ARESETN = 1'b0;
  logic start = 1'b0, abort = 1'b0, done_clr = 1'b0;
  logic m_valid = 1'b0, m_ready = 1'b0, m_last = 1'b0;
  logic [15:0] cfg_item_num = '0;
  logic [19:0] cfg_addr_i = '0, cfg_addr_j = '0;
  logic gen, run, busy, done, err;
  logic [15:0] item_a;
  logic [19:0] addr_i, addr_j;
  logic [31:0] cycles;
  int n_cmp = 0, n_bad = 0, cyc_n = 0, s_edge = 0;
  logic [31:0] exp_q[$];

  always #5 AXIS_ACLK = ~AXIS_ACLK;

  hv_sequencer #(.SETTLE_CYCLES(2), .TIMEOUT(32'd16)) dut (
    .AXIS_ACLK(AXIS_ACLK), .AXIS_ARESETN(AXIS_ARESETN), .start(start), .abort(abort),
    .done_clr(done_clr), .cfg_item_num(cfg_item_num), .cfg_addr_i(cfg_addr_i),
    .cfg_addr_j(cfg_addr_j), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .gen(gen), .item_a(item_a), .run(run), .addr_i(addr_i), .addr_j(addr_j),
    .busy(busy), .done(done), .err(err), .cycles(cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge AXIS_ACLK);
    #1;
    cyc_n++;
  endtask

  task automatic do_start(input logic [15:0] n, input logic [19:0] ai, input logic [19:0] aj);
    cfg_item_num = n;
    cfg_addr_i = ai;
    cfg_addr_j = aj;
    start = 1'b1;
    tick();
    start = 1'b0;
    s_edge = cyc_n;
    for (int i = 0; i < int'(n); i++) exp_q.push_back(32'(i));
  endtask

  task automatic drain_gen;
    int g = 0;
    while (gen && g < 70000) begin
      check("item_a", 32'(item_a), exp_q.size() != 0 ? exp_q.pop_front() : 32'hDEAD_BEEF);
      g++;
      tick();
    end
    check("gen_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_run(input int exp_low);
    int n = 0;
    while (!run && n < 100) begin
      n++;
      tick();
    end
    check("settle_len", 32'(n), 32'(exp_low));
  endtask

  initial begin
    int beats, stall, lim, n;
    tick();
    tick();
    check("rst_gen", 32'(gen), 32'd0);
    check("rst_run", 32'(run), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    check("rst_cycles", cycles, 32'd0);
    check("rst_addr", 32'({item_a, addr_i}), 32'd0);
    AXIS_ARESETN = 1'b1;
    tick();
    // 1000-entry generation, settle gap, final beat coinciding with start
    do_start(16'd1000, 20'h12345, 20'h0ABCD);
    check("gen_first", 32'(gen), 32'd1);
    check("addr_i", 32'(addr_i), 32'h12345);
    check("addr_j", 32'(addr_j), 32'h0ABCD);
    drain_gen();
    wait_run(3);
    check("run_no_gen", 32'(gen), 32'd0);
    start = 1'b1;
    m_valid = 1'b1;
    m_ready = 1'b1;
    m_last = 1'b1;
    tick();
    {start, m_valid, m_ready, m_last} = 4'b0;
    check("last_done", 32'(done), 32'd1);
    check("last_run", 32'(run), 32'd0);
    check("last_busy", 32'(busy), 32'd0);
    check("last_cycles", cycles, 32'(cyc_n - s_edge));
    check("start_ignored_gen", 32'(gen), 32'd0);
    tick();
    check("start_ignored_busy", 32'(busy), 32'd0);
    done_clr = 1'b1;
    tick();
    done_clr = 1'b0;
    check("clr_done", 32'(done), 32'd0);
    // zero items: straight to settle, then 5 beats with random stalls
    do_start(16'd0, 20'h00001, 20'h00002);
    check("skip_gen", 32'(gen), 32'd0);
    wait_run(3);
    beats = 0;
    stall = 0;
    lim = 0;
    while (beats < 5 && lim < 200) begin
      m_valid = 1'b1;
      m_ready = (stall >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
      m_last = (beats == 4);
      if (m_ready) begin
        beats++;
        stall = 0;
      end else stall++;
      tick();
      lim++;
    end
    {m_valid, m_ready, m_last} = 3'b0;
    check("beats_done", 32'(done), 32'd1);
    check("beats_run", 32'(run), 32'd0);
    check("beats_err", 32'(err), 32'd0);
    check("beats_cycles", cycles, 32'(cyc_n - s_edge));
    // restart from DONE, then starve the stream into timeout
    do_start(16'd3, 20'h00010, 20'h00020);
    check("redone_clr", 32'(done), 32'd0);
    drain_gen();
    wait_run(3);
    n = 0;
    while (run && n < 100) begin
      n++;
      tick();
    end
    check("run_len", 32'(n), 32'd16);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_done", 32'(done), 32'd1);
    check("tmo_cycles", cycles, 32'd22);
    done_clr = 1'b1;
    tick();
    done_clr = 1'b0;
    check("clr_err", 32'({done, err}), 32'd0);
    check("clr_idle", 32'(busy), 32'd0);
    // abort mid-generation at address 37, then restart
    do_start(16'd100, 20'h00003, 20'h00004);
    for (int i = 0; i < 38; i++) begin
      check("item_a", 32'(item_a), exp_q.pop_front());
      if (i < 37) tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_gen", 32'(gen), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    exp_q.delete();
    tick();
    check("abort_idle", 32'(busy), 32'd0);
    do_start(16'd100, 20'h00003, 20'h00004);
    drain_gen();
    wait_run(3);
    m_valid = 1'b1;
    m_ready = 1'b1;
    tick();
    tick();
    {m_valid, m_ready} = 2'b0;
    check("pre_rst_run", 32'(run), 32'd1);
    // asynchronous reset between clock edges
    #3;
    AXIS_ARESETN = 1'b0;
    #1;
    check("arst_run", 32'(run), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_cycles", cycles, 32'd0);
    check("arst_addr", 32'(addr_i), 32'd0);
    tick();
    AXIS_ARESETN = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hv_sequencer.md
# hv_sequencer

Phase sequencer for the hypervector datapath on the AXI-Stream clock. It replaces the free-running `run`/`gen` register bits with one controlled sequence: latch configuration, generate the item memory, settle, run the stream until the final output beat, then report done. It also drives item-memory addressing and the `addr_i`/`addr_j` bounds, and reports cycle count and timeout status back to the AXI-Lite register file.

## Interface
Parameters:
- SETTLE_CYCLES, 2: idle cycles between end of GEN and assertion of `run`.
- TIMEOUT, 32'h00FF_FFFF: maximum RUN-phase cycles without an output handshake before abort with error.

Ports:
- AXIS_ACLK  in  1  clock, the only clock.
- AXIS_ARESETN  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse requesting a new sequence.
- abort  in  1  single-cycle pulse; stops any phase.
- done_clr  in  1  clears `done` and `err`.
- cfg_item_num  in  16  number of item-memory entries to generate.
- cfg_addr_i  in  20  `addr_i` bound for `get_ctrl`.
- cfg_addr_j  in  20  `addr_j` bound for `get_ctrl` and the core.
- m_valid  in  1  M_AXIS_TVALID (monitor only).
- m_ready  in  1  M_AXIS_TREADY (monitor only).
- m_last  in  1  M_AXIS_TLAST (monitor only).
- gen  out  1  item-memory generation enable (to xorshift and the core).
- item_a  out  16  item-memory write address.
- run  out  1  datapath run; `get_ctrl`, `stream_ctrl` and `buffer_ctrl` are reset by `~run`.
- addr_i  out  20  latched `cfg_addr_i`.
- addr_j  out  20  latched `cfg_addr_j`.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  sticky completion flag.
- err  out  1  sticky timeout flag.
- cycles  out  32  saturating count of busy cycles in the last or current sequence.

## Operation
- States: IDLE, GEN, SETTLE, RUN, DONE.
- IDLE:
  - On `start`, latch the three cfg inputs, clear `cycles`, `done` and `err`.
  - Go to GEN if `cfg_item_num` != 0, otherwise go to SETTLE.
- GEN:
  - `gen`=1; `item_a` starts at 0 and increments each cycle.
  - On the cycle where `item_a` == latched item_num−1, go to SETTLE.
  - Result: exactly item_num cycles with `gen`=1, covering addresses 0..N−1.
- SETTLE: `gen`=`run`=0. A down-counter loaded with SETTLE_CYCLES; go to RUN when it reaches 0 (SETTLE_CYCLES=0 gives a 1-cycle pass-through).
- RUN:
  - `run`=1. A beat is `m_valid & m_ready`.
  - On a beat with `m_last`=1, go to DONE with `done`=1.
  - A watchdog is cleared on every beat and otherwise increments. When it reaches TIMEOUT, go to DONE with `done`=1 and `err`=1.
- DONE:
  - `done` holds. `done_clr` clears `done`/`err` and returns to IDLE.
  - `start` in DONE behaves as `start` in IDLE, going directly to GEN/SETTLE.
- `abort` in any busy state: next state IDLE; `gen`/`run` drop the next cycle; `done` is not set and `err` is unchanged.
- Priority when events coincide: `abort` > last beat > timeout > `start`. `start` while busy is ignored.
- `cycles` increments each cycle `busy`=1 and saturates at 32'hFFFF_FFFF.
- Reset values: state IDLE; `gen`, `run`, `busy`, `done`, `err` = 0; `item_a`, `addr_i`, `addr_j`, `cycles` = 0.
- Reset mid-sequence: all outputs take their reset values immediately (asynchronous). No partial-state recovery.

## Timing
- All outputs are registered and change only on the AXIS_ACLK rising edge.
- `start` at edge k gives `gen`=1 from edge k+1.
- The last `gen` cycle is followed by SETTLE_CYCLES+1 cycles with both `gen` and `run` low.
- A final beat at edge k gives `run`=0, `done`=1, `busy`=0 from edge k+1.
- `run` must never be high while `gen` is high; assert this invariant in simulation.

## Structure
- Package `hv_seq_pkg`:
  - state enum `seq_state_t`.
  - width constants ITEM_W=16, ADDR_W=20, CYC_W=32.
- One sub-module, `sat_counter` (clear, enable, saturating, width parameter). It is instantiated for `cycles` and for the watchdog.

## Test plan
- cfg_item_num=1000, SETTLE_CYCLES=2, `start` → `gen` high exactly 1000 cycles, `item_a` goes 0..999, `run` rises 3 cycles after `gen` falls.
- cfg_item_num=0, `start` → GEN skipped; `run` rises SETTLE_CYCLES+1 cycles after `start`.
- RUN with beats and `m_last` on the 5th beat under random `m_ready` stalls → `done`=1 the next cycle, `run`=0, `cycles` equals the busy cycle count.
- TIMEOUT=16 with no beats → `err`=1 and `done`=1 after 16 RUN cycles; `done_clr` clears both and returns to IDLE.
- `abort` during GEN at `item_a`=37 → `gen`=0 next cycle, state IDLE, `done`=0; a following `start` restarts `item_a` at 0.
- Assert `AXIS_ARESETN`=0 mid-RUN → `run`, `busy` and `cycles` are 0 without waiting for a clock edge; `start` in the same cycle as the last beat is ignored.
